// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default sizes for the regfile writeback arbiter slice.
//   XLEN     data width of a register / write
//   REG_AW   register index width (x0 is hardwired zero)
//   NUM_REGS number of architectural registers
//   NREQ     default number of writeback requesters
package regfile_wb_arbiter_pkg;

    localparam int XLEN     = 64;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int NREQ     = 2;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xlen_t;

    // One committed regfile write: destination plus data.
    typedef struct packed {
        reg_idx_t rd;
        xlen_t    data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback request bus, the regfile write port and the
// scoreboard query/issue signals.
//   master : producer / issue side (drives requests, issue and source indices)
//   slave  : the arbiter (grants, performs the write, answers hazard queries)
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN   = regfile_wb_arbiter_pkg::XLEN,
    parameter int NREQ   = regfile_wb_arbiter_pkg::NREQ,
    parameter int REG_AW = regfile_wb_arbiter_pkg::REG_AW
);
    // Writeback requests, requester k at [k*REG_AW +: REG_AW] / [k*XLEN +: XLEN]
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*REG_AW-1:0] req_rd;
    logic [NREQ*XLEN-1:0]   req_data;
    logic [NREQ-1:0]        req_ready;

    // Registered regfile write port
    logic                   rf_write;
    logic [REG_AW-1:0]      rf_rd;
    logic [XLEN-1:0]        rf_wdata;

    // Issue-side hazard interface
    logic                   issue_valid;
    logic [REG_AW-1:0]      issue_rd;
    logic [REG_AW-1:0]      rs1;
    logic [REG_AW-1:0]      rs2;
    logic                   busy_rs1;
    logic                   busy_rs2;
    logic                   busy_rd;
    logic                   sb_err;

    modport master (
        output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
        input  req_ready, rf_write, rf_rd, rf_wdata, busy_rs1, busy_rs2, busy_rd, sb_err
    );

    modport slave (
        input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
        output req_ready, rf_write, rf_rd, rf_wdata, busy_rs1, busy_rs2, busy_rd, sb_err
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter. The pointer names the last winner;
// the search starts one past it and wraps, so the last winner has lowest
// priority. The pointer register lives in the parent.
//   req     in  N      request vector
//   ptr     in  IW     last winner index
//   gnt     out N      one-hot grant (zero when no request)
//   gnt_idx out IW     index of the granted requester
//   any     out 1      some requester is granted
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regfile write port among NREQ writeback requesters with
// round-robin arbitration, registers the granted write for one cycle, and
// keeps a pending-write scoreboard for RAW/WAW hazard checks on x1..x31.
//   clk, rst  clock (rising edge), asynchronous active-high reset
//   bus       regfile_wb_arbiter_if.slave: requests/grants, registered write
//             port (rf_write/rf_rd/rf_wdata), issue + source queries,
//             busy_rs1/busy_rs2/busy_rd and sticky sb_err
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN   = regfile_wb_arbiter_pkg::XLEN,
    parameter int NREQ   = regfile_wb_arbiter_pkg::NREQ,
    parameter int REG_AW = regfile_wb_arbiter_pkg::REG_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int IW   = $clog2(NREQ);
    localparam int NREG = 1 << REG_AW;

    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gnt_idx;
    logic [NREQ-1:0]   gnt;
    logic              any_gnt;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic              clr_hit;
    logic              waw_err;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_gnt)
    );

    assign bus.req_ready = gnt;
    assign win_rd        = bus.req_rd[gnt_idx*REG_AW +: REG_AW];
    assign win_data      = bus.req_data[gnt_idx*XLEN +: XLEN];

    // A grant to x0 is still accepted and advances the pointer, but never
    // reaches the write port. Index/data only load on a real write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= IW'(NREQ - 1);
            bus.rf_write <= 1'b0;
            bus.rf_rd    <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_write <= any_gnt && (win_rd != '0);
            if (any_gnt) begin
                rr_ptr <= gnt_idx;
                if (win_rd != '0) begin
                    bus.rf_rd    <= win_rd;
                    bus.rf_wdata <= win_data;
                end
            end
        end
    end

    // Clear first, then set: a new producer issuing to the register being
    // written this cycle keeps it pending.
    always_comb begin
        pend_nxt = pend;
        if (bus.rf_write)
            pend_nxt[bus.rf_rd] = 1'b0;
        if (bus.issue_valid)
            pend_nxt[bus.issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    assign clr_hit = bus.rf_write && (bus.rf_rd == bus.issue_rd);
    assign waw_err = bus.issue_valid && (bus.issue_rd != '0)
                     && pend[bus.issue_rd] && !clr_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            bus.sb_err <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (waw_err)
                bus.sb_err <= 1'b1;
        end
    end

    // pend[0] is held at zero, so x0 queries always read not-busy.
    assign bus.busy_rs1 = pend[bus.rs1];
    assign bus.busy_rs2 = pend[bus.rs2];
    assign bus.busy_rd  = pend[bus.issue_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus pushes expected grants and writes into queues,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ), .REG_AW(REG_AW)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [NREQ-1:0] exp_rdy_q[$];
    wb_req_t         exp_wr_q[$];
    logic [NREQ-1:0] mon_rdy;
    wb_req_t         mon_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req_valid   = '0;
        bus.req_rd      = '0;
        bus.req_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;
    endtask

    task automatic set_req(input int k, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
        bus.req_valid[k]                = 1'b1;
        bus.req_rd[k*REG_AW +: REG_AW]  = rd;
        bus.req_data[k*XLEN +: XLEN]    = d;
    endtask

    task automatic exp_gnt(input logic [NREQ-1:0] r);
        exp_rdy_q.push_back(r);
    endtask

    task automatic exp_wr(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
        exp_wr_q.push_back(wb_req_t'{rd: rd, data: d});
    endtask

    // Monitor: grants whenever any request is up, writes whenever rf_write.
    always @(negedge clk) begin
        if (!rst) begin
            if (|bus.req_valid) begin
                if (exp_rdy_q.size() == 0) begin
                    n_total++;
                    $display("FAIL req_ready: got %0h with no grant expected", bus.req_ready);
                end else begin
                    mon_rdy = exp_rdy_q.pop_front();
                    check("req_ready", 64'(bus.req_ready), 64'(mon_rdy));
                end
            end
            if (bus.rf_write) begin
                if (exp_wr_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rf_write: unexpected write rd=%0d data=%0h", bus.rf_rd, bus.rf_wdata);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    check("rf_rd", 64'(bus.rf_rd), 64'(mon_wr.rd));
                    check("rf_wdata", 64'(bus.rf_wdata), 64'(mon_wr.data));
                end
            end
        end
    end

    initial begin
        #100000;
        n_total++;
        $display("FAIL watchdog: time limit reached");
        summary();
    end

    initial begin
        idle();
        #1 rst = 1'b1;
        repeat (2) mid();
        check("rst_rf_write", 64'(bus.rf_write), 64'd0);
        check("rst_rf_rd",    64'(bus.rf_rd),    64'd0);
        check("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
        check("rst_sb_err",   64'(bus.sb_err),   64'd0);
        check("rst_ready",    64'(bus.req_ready), 64'd0);
        cyc();
        rst = 1'b0;

        // 1: single request, one-cycle latency
        set_req(0, 5, 64'hDEAD);
        exp_gnt(2'b01); exp_wr(5, 64'hDEAD);
        cyc(); idle();
        mid();
        cyc(); mid();
        check("t1_no_extra_write", 64'(bus.rf_write), 64'd0);

        // 2: both valid from reset -> 0,1,0,1
        @(negedge clk); #2 rst = 1'b1;
        cyc(); rst = 1'b0;
        set_req(0, 3, 64'hA0);
        set_req(1, 4, 64'hB1);
        for (int k = 0; k < 4; k++) begin
            exp_gnt((k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) exp_wr(3, 64'hA0); else exp_wr(4, 64'hB1);
            cyc();
        end
        idle();

        // 3: RAW busy set by issue, cleared the cycle after the write
        bus.issue_valid = 1'b1; bus.issue_rd = 7; bus.rs1 = 7;
        mid(); check("t3_no_bypass", 64'(bus.busy_rs1), 64'd0);
        cyc(); bus.issue_valid = 1'b0;
        mid(); check("t3_busy_set", 64'(bus.busy_rs1), 64'd1);
        cyc(); set_req(0, 7, 64'h77); exp_gnt(2'b01); exp_wr(7, 64'h77);
        mid(); check("t3_busy_before_wb", 64'(bus.busy_rs1), 64'd1);
        cyc(); bus.req_valid = '0;
        mid(); check("t3_busy_during_wr", 64'(bus.busy_rs1), 64'd1);
        cyc();
        mid(); check("t3_busy_cleared", 64'(bus.busy_rs1), 64'd0);

        // 4: clear of x9 coincides with a new issue to x9
        cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 9;
        mid();
        cyc(); bus.issue_valid = 1'b0; set_req(1, 9, 64'h99); exp_gnt(2'b10); exp_wr(9, 64'h99);
        mid();
        cyc(); bus.req_valid = '0; bus.issue_valid = 1'b1; bus.issue_rd = 9;
        mid(); check("t4_busy_rd", 64'(bus.busy_rd), 64'd1);
        check("t4_write_now", 64'(bus.rf_write), 64'd1);
        cyc(); bus.issue_valid = 1'b0; bus.rs2 = 9;
        mid(); check("t4_still_pending", 64'(bus.busy_rs2), 64'd1);
        check("t4_no_err", 64'(bus.sb_err), 64'd0);

        // 5: WAW issue without intervening write -> sticky sb_err
        cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 7;
        mid(); check("t5_busy_rd_first", 64'(bus.busy_rd), 64'd0);
        cyc();
        mid(); check("t5_busy_rd_second", 64'(bus.busy_rd), 64'd1);
        check("t5_err_not_yet", 64'(bus.sb_err), 64'd0);
        cyc(); bus.issue_valid = 1'b0;
        mid(); check("t5_err_set", 64'(bus.sb_err), 64'd1);
        repeat (3) cyc();
        mid(); check("t5_err_sticky", 64'(bus.sb_err), 64'd1);

        // 6: grant to x0 is accepted, advances the pointer, never writes
        cyc(); set_req(1, 0, 64'hFF); exp_gnt(2'b10);
        bus.rs1 = 0; bus.issue_valid = 1'b1; bus.issue_rd = 0;
        mid(); check("t6_busy_rd_x0", 64'(bus.busy_rd), 64'd0);
        cyc(); bus.req_valid = '0; bus.issue_valid = 1'b0;
        mid(); check("t6_no_x0_write", 64'(bus.rf_write), 64'd0);
        check("t6_busy_rs1_x0", 64'(bus.busy_rs1), 64'd0);
        check("t6_no_err_x0", 64'(bus.sb_err), 64'd1);
        cyc(); set_req(0, 2, 64'h22); set_req(1, 3, 64'h33);
        exp_gnt(2'b01); exp_wr(2, 64'h22);
        cyc(); bus.req_valid[0] = 1'b0;
        exp_gnt(2'b10); exp_wr(3, 64'h33);
        cyc(); idle(); bus.rs2 = 9;

        // Reset while a write is on the port
        set_req(0, 11, 64'h1234); exp_gnt(2'b01); exp_wr(11, 64'h1234);
        cyc(); bus.req_valid = '0;
        mid();
        #2 rst = 1'b1;
        #1;
        check("mrst_rf_write", 64'(bus.rf_write), 64'd0);
        check("mrst_rf_rd",    64'(bus.rf_rd),    64'd0);
        check("mrst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
        check("mrst_sb_err",   64'(bus.sb_err),   64'd0);
        check("mrst_pend",     64'(bus.busy_rs2), 64'd0);
        cyc(); rst = 1'b0;

        repeat (3) cyc();
        check("rdy_q_drained", 64'(exp_rdy_q.size()), 64'd0);
        check("wr_q_drained",  64'(exp_wr_q.size()),  64'd0);
        summary();
    end

endmodule
